// File: rtl/dllp_receive_if.sv
// DLLP AXI-Stream link from the PHY receive path into the data link layer.
interface dllp_receive_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 5
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/dllp_receive.sv
// DLLP receive front end: assembles two-beat DLLPs, checks CRC-16, decodes
// Ack/Nak, VC0 flow-control and PM DLLPs into one-cycle result pulses.
module dllp_receive #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        link_up_i,
  dllp_receive_if.slave s_axis,
  output logic        ack_valid_o,
  output logic        nak_valid_o,
  output logic [11:0] ack_seq_o,
  output logic        fc_valid_o,
  output logic [1:0]  fc_kind_o,
  output logic [1:0]  fc_type_o,
  output logic [7:0]  fc_hdr_o,
  output logic [11:0] fc_data_o,
  output logic        pm_valid_o,
  output logic [2:0]  pm_type_o,
  output logic        bad_dllp_o,
  output logic [15:0] bad_dllp_count_o
);
  typedef enum logic [1:0] {IDLE, BEAT_B, DROP} state_t;

  state_t      state;
  logic [31:0] dllp_q;
  logic [15:0] crc_q;
  logic        tready_q;

  // Serial LFSR over the 32 header bits, byte 0 first, each byte LSB first.
  function automatic logic [15:0] crc32_step(input logic [31:0] d);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      if (d[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h100B;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  logic [15:0] crc_next;
  logic [7:0]  exp_b4, exp_b5;
  logic [7:0]  b0, b1, b2, b3;
  logic        hs, beat_a_ok, beat_b_ok, crc_ok, bad_ev;
  logic        is_ack, is_nak, is_fc, is_pm;
  logic        unused_tuser;

  assign s_axis.tready = tready_q;
  assign hs            = s_axis.tvalid & tready_q;
  assign crc_next      = crc32_step(s_axis.tdata[31:0]);
  assign {b3, b2, b1, b0} = dllp_q;
  assign unused_tuser  = ^s_axis.tuser[USER_WIDTH-1:2];

  always_comb begin
    exp_b4 = '0;
    exp_b5 = '0;
    for (int k = 0; k < 8; k++) begin
      exp_b4[7-k] = ~crc_q[8+k];
      exp_b5[7-k] = ~crc_q[k];
    end
  end

  assign crc_ok    = (s_axis.tdata[7:0] == exp_b4) && (s_axis.tdata[15:8] == exp_b5);
  assign beat_a_ok = s_axis.tuser[0] & ~s_axis.tlast & ~s_axis.tuser[1] &
                     (s_axis.tkeep == {KEEP_WIDTH{1'b1}});
  assign beat_b_ok = s_axis.tlast & ~s_axis.tuser[1] & (s_axis.tkeep == KEEP_WIDTH'(3));

  assign bad_ev = link_up_i & hs &
                  (((state == IDLE) & s_axis.tuser[0] & ~beat_a_ok) |
                   ((state == BEAT_B) & (~beat_b_ok | ~crc_ok)));

  // FC type 2'b11 and set bit 3 are reserved encodings; non-VC0 FC is silent.
  assign is_ack = (b0 == 8'h00);
  assign is_nak = (b0 == 8'h10);
  assign is_fc  = (b0[7:6] != 2'b00) && (b0[5:4] != 2'b11) && (b0[3:0] == 4'h0);
  assign is_pm  = (b0[7:3] == 5'b00100) && (b0[2:0] <= 3'd4);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state            <= IDLE;
      dllp_q           <= '0;
      crc_q            <= '0;
      tready_q         <= 1'b0;
      ack_valid_o      <= 1'b0;
      nak_valid_o      <= 1'b0;
      ack_seq_o        <= '0;
      fc_valid_o       <= 1'b0;
      fc_kind_o        <= '0;
      fc_type_o        <= '0;
      fc_hdr_o         <= '0;
      fc_data_o        <= '0;
      pm_valid_o       <= 1'b0;
      pm_type_o        <= '0;
      bad_dllp_o       <= 1'b0;
      bad_dllp_count_o <= '0;
    end else begin
      tready_q    <= 1'b1;
      ack_valid_o <= 1'b0;
      nak_valid_o <= 1'b0;
      fc_valid_o  <= 1'b0;
      pm_valid_o  <= 1'b0;
      bad_dllp_o  <= bad_ev;
      if (bad_ev && bad_dllp_count_o != 16'hFFFF)
        bad_dllp_count_o <= bad_dllp_count_o + 16'd1;

      if (!link_up_i) begin
        state <= IDLE;
      end else if (hs) begin
        case (state)
          IDLE: begin
            if (s_axis.tuser[0] && beat_a_ok) begin
              dllp_q <= s_axis.tdata[31:0];
              crc_q  <= crc_next;
              state  <= BEAT_B;
            end else begin
              state  <= s_axis.tlast ? IDLE : DROP;
            end
          end
          BEAT_B: begin
            state <= s_axis.tlast ? IDLE : DROP;
            if (beat_b_ok && crc_ok) begin
              if (is_ack || is_nak) begin
                ack_valid_o <= is_ack;
                nak_valid_o <= is_nak;
                ack_seq_o   <= {b2[3:0], b3};
              end else if (is_fc) begin
                fc_valid_o <= 1'b1;
                fc_kind_o  <= {b0[7] & b0[6], b0[6] & ~b0[7]};
                fc_type_o  <= b0[5:4];
                fc_hdr_o   <= {b1[5:0], b2[7:6]};
                fc_data_o  <= {b2[3:0], b3};
              end else if (is_pm) begin
                pm_valid_o <= 1'b1;
                pm_type_o  <= b0[2:0];
              end
            end
          end
          DROP:    if (s_axis.tlast) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dllp_receive.sv
// Directed bench for dllp_receive: hand-built DLLPs with a reference CRC.
module tb_dllp_receive;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic link_up = 1'b1;
  logic        ack_valid, nak_valid, fc_valid, pm_valid, bad_dllp;
  logic [11:0] ack_seq, fc_data;
  logic [1:0]  fc_kind, fc_type;
  logic [7:0]  fc_hdr;
  logic [2:0]  pm_type;
  logic [15:0] bad_cnt;
  int errors = 0;
  int checks = 0;

  dllp_receive_if #(.DATA_WIDTH(32), .USER_WIDTH(5)) axis ();

  dllp_receive #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(5)) dut (
    .clk_i(clk), .rst_i(rst_n), .link_up_i(link_up), .s_axis(axis.slave),
    .ack_valid_o(ack_valid), .nak_valid_o(nak_valid), .ack_seq_o(ack_seq),
    .fc_valid_o(fc_valid), .fc_kind_o(fc_kind), .fc_type_o(fc_type),
    .fc_hdr_o(fc_hdr), .fc_data_o(fc_data), .pm_valid_o(pm_valid),
    .pm_type_o(pm_type), .bad_dllp_o(bad_dllp), .bad_dllp_count_o(bad_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: returns {byte5, byte4} for header word {b3,b2,b1,b0}.
  function automatic logic [15:0] ref_crc(input logic [31:0] w);
    logic [15:0] c;
    logic [7:0] b4, b5;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      fb = w[i] ^ c[15];
      c = c << 1;
      if (fb) c = c ^ 16'h100B;
    end
    for (int k = 0; k < 8; k++) begin
      b4[7-k] = ~c[8+k];
      b5[7-k] = ~c[k];
    end
    return {b5, b4};
  endfunction

  // Present one beat for a cycle; returns at the next falling edge.
  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [4:0] u);
    axis.tdata = d; axis.tkeep = k; axis.tlast = l; axis.tuser = u; axis.tvalid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    axis.tvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic beat_a(input logic [31:0] w);
    beat(w, 4'hF, 1'b0, 5'b00001);
  endtask

  task automatic beat_b(input logic [31:0] w, input logic [15:0] flip);
    beat({16'h0, ref_crc(w) ^ flip}, 4'h3, 1'b1, 5'b00001);
  endtask

  initial begin
    axis.tdata = '0; axis.tkeep = '0; axis.tlast = 1'b0; axis.tuser = '0; axis.tvalid = 1'b0;
    @(negedge clk);
    chk("rst_tready", axis.tready, 0);
    chk("rst_ack_valid", ack_valid, 0);
    chk("rst_bad", bad_dllp, 0);
    chk("rst_count", bad_cnt, 0);
    chk("rst_ack_seq", ack_seq, 0);
    chk("rst_fc_fields", {fc_kind, fc_type, fc_hdr, fc_data, pm_type}, 0);
    rst_n = 1'b1;
    idle();
    chk("tready_up", axis.tready, 1);

    // Ack seq 0x005
    beat_a(32'h05000000); beat_b(32'h05000000, 16'h0);
    chk("ack_valid", ack_valid, 1);
    chk("ack_seq", ack_seq, 12'h005);
    chk("ack_no_bad", bad_dllp, 0);
    idle();
    chk("ack_one_cycle", ack_valid, 0);

    // UpdateFC-P hdr 0x20 data 0x180
    beat_a(32'h80010880); beat_b(32'h80010880, 16'h0);
    chk("ufc_valid", fc_valid, 1);
    chk("ufc_kind_type", {fc_kind, fc_type}, 4'b0000);
    chk("ufc_hdr", fc_hdr, 8'h20);
    chk("ufc_data", fc_data, 12'h180);
    idle();

    // Nak seq 0x123 with byte5 bit 0 flipped
    beat_a(32'h23010010); beat_b(32'h23010010, 16'h0100);
    chk("nak_crc_no_pulse", nak_valid, 0);
    chk("nak_crc_bad", bad_dllp, 1);
    chk("nak_crc_count", bad_cnt, 1);
    chk("nak_seq_held", ack_seq, 12'h005);
    idle();
    chk("bad_one_cycle", bad_dllp, 0);

    // Three-beat DLLP-flagged frame, then InitFC1-NP hdr 0x11 data 0x234
    beat_a(32'h05000000);
    beat(32'h0, 4'h3, 1'b0, 5'b00001);
    chk("3beat_bad", bad_dllp, 1);
    chk("3beat_count", bad_cnt, 2);
    beat(32'h0, 4'h3, 1'b1, 5'b00001);
    chk("3beat_drop_quiet", bad_dllp, 0);
    beat_a(32'h34420450);
    chk("3beat_drop_count", bad_cnt, 2);
    beat_b(32'h34420450, 16'h0);
    chk("ifc1_valid", fc_valid, 1);
    chk("ifc1_kind_type", {fc_kind, fc_type}, 4'b0101);
    chk("ifc1_hdr", fc_hdr, 8'h11);
    chk("ifc1_data", fc_data, 12'h234);

    // Eight back-to-back Acks, seq 0..7
    for (int i = 0; i < 8; i++) begin
      beat_a({i[7:0], 24'h0});
      if (i > 0) chk("b2b_gap", ack_valid, 0);
      beat_b({i[7:0], 24'h0}, 16'h0);
      chk("b2b_ack", ack_valid, 1);
      chk("b2b_seq", ack_seq, i);
      chk("b2b_tready", axis.tready, 1);
    end
    idle();

    // Link drops between Beat A and Beat B: no pulse, fields held
    beat_a(32'h09000000);
    link_up = 1'b0;
    beat_b(32'h09000000, 16'h0);
    chk("linkdown_quiet", {ack_valid, bad_dllp}, 0);
    chk("linkdown_seq_held", ack_seq, 12'h007);
    link_up = 1'b1;
    idle();

    // PM type 4, then vendor 0x30 with good CRC (silent)
    beat_a(32'h00000024); beat_b(32'h00000024, 16'h0);
    chk("pm_valid", pm_valid, 1);
    chk("pm_type", pm_type, 3'd4);
    beat_a(32'h00000030); beat_b(32'h00000030, 16'h0);
    chk("vendor_quiet", {ack_valid, nak_valid, fc_valid, pm_valid, bad_dllp}, 0);
    chk("vendor_count", bad_cnt, 2);

    // Reset after Beat A of an Ack, then InitFC2-Cpl hdr 0x05 data 0x00A
    beat_a(32'h01000000);
    axis.tvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tready", axis.tready, 0);
    chk("midrst_count", bad_cnt, 0);
    rst_n = 1'b1;
    idle();
    beat_a(32'h0A4001E0); beat_b(32'h0A4001E0, 16'h0);
    chk("ifc2_no_ack", ack_valid, 0);
    chk("ifc2_valid", fc_valid, 1);
    chk("ifc2_kind_type", {fc_kind, fc_type}, 4'b1010);
    chk("ifc2_hdr", fc_hdr, 8'h05);
    chk("ifc2_data", fc_data, 12'h00A);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dllp_receive.md
# dllp_receive

Data link layer receive front end that consumes the DLLP AXI-Stream produced by the PHY receive path (`m_dllp_axis_*`) and assembles each 6-byte DLLP from two beats. It checks the DLLP CRC-16, decodes the type, and emits one-cycle result pulses for Ack/Nak, flow-control (InitFC1/InitFC2/UpdateFC) and power-management DLLPs. The retry buffer, credit tracker and LTSSM/PM logic consume these pulses; corrupt or malformed DLLPs are dropped and counted.

## Interface
- DATA_WIDTH, 32: AXIS data width; only 32 is supported.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- USER_WIDTH, 5: tuser width. Bit 0 = DLLP flag (1 = DLLP, 0 = TLP). Bit 1 = PHY framing error. Bits 4:2 are ignored.

- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-low reset.
- link_up_i  in  1  DL link up; when low, stream is drained and no results are emitted.
- s_axis_tdata  in  DATA_WIDTH  DLLP bytes; byte n at [8n+7:8n].
- s_axis_tkeep  in  KEEP_WIDTH  byte enables.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of DLLP.
- s_axis_tuser  in  USER_WIDTH  see USER_WIDTH.
- s_axis_tready  out  1  0 in reset; 1 otherwise, with no backpressure.
- ack_valid_o  out  1  pulse: Ack received.
- nak_valid_o  out  1  pulse: Nak received.
- ack_seq_o  out  12  AckNak_Seq_Num, held until next Ack/Nak.
- fc_valid_o  out  1  pulse: VC0 FC DLLP received.
- fc_kind_o  out  2  0 = UpdateFC, 1 = InitFC1, 2 = InitFC2.
- fc_type_o  out  2  0 = P, 1 = NP, 2 = Cpl.
- fc_hdr_o  out  8  HdrFC.
- fc_data_o  out  12  DataFC.
- pm_valid_o  out  1  pulse: PM DLLP received.
- pm_type_o  out  3  byte0[2:0] of PM DLLP.
- bad_dllp_o  out  1  pulse: CRC error, malformed DLLP or PHY error.
- bad_dllp_count_o  out  16  saturating count of bad_dllp_o pulses.

## Operation
- Frame format:
  - Beat A: tdata = DLLP bytes 0..3, tkeep = 4'hF, tlast = 0.
  - Beat B: tdata[15:0] = CRC bytes 4, 5, tkeep = 4'h3, tlast = 1.
- FSM states: IDLE, BEAT_B, DROP.
  - IDLE, valid, tuser[0] = 1, tlast = 0, tkeep = F, tuser[1] = 0: latch bytes 0..3 and go to BEAT_B.
  - IDLE, tuser[0] = 0 (TLP): silently discard. Stay in IDLE if tlast = 1, else go to DROP.
  - IDLE, DLLP beat with tlast = 1, tkeep ≠ F or tuser[1] = 1: bad_dllp_o. Stay in IDLE if tlast = 1, else go to DROP.
  - BEAT_B, valid, tlast = 1, tkeep = 3, tuser[1] = 0: check CRC, decode, go to IDLE.
  - BEAT_B, any other valid beat: bad_dllp_o. Go to IDLE if tlast = 1, else go to DROP.
  - DROP: discard beats until a tlast beat, then go to IDLE. No further bad pulse is emitted.
- CRC:
  - Polynomial 0x100B, LFSR seeded 0xFFFF.
  - Covers bytes 0..3, processed in order with each byte LSB first.
  - Expected byte4 = ~{c[8],c[9],…,c[15]}. Expected byte5 = ~{c[0],c[1],…,c[7]}.
  - A mismatch produces bad_dllp_o and no decode.
- Decode (byte0):
  - 0x00 = Ack; 0x10 = Nak. ack_seq_o = {byte2[3:0], byte3}.
  - 0x40/0x50/0x60 = InitFC1 P/NP/Cpl; 0xC0/0xD0/0xE0 = InitFC2 P/NP/Cpl; 0x80/0x90/0xA0 = UpdateFC P/NP/Cpl.
    - fc_hdr_o = {byte1[5:0], byte2[7:6]}; fc_data_o = {byte2[3:0], byte3}.
  - FC DLLPs with byte0[2:0] ≠ 0 (non-VC0) are CRC-checked but produce no pulse.
  - 0x20–0x24 = PM, pm_type_o = byte0[2:0].
  - Any other type with good CRC (including vendor 0x30) is discarded with no pulse and no bad pulse.
- link_up_i low:
  - FSM is forced to IDLE and all pulses are suppressed; the stream is still accepted and discarded.
  - Held result fields are not cleared.
- At most one result pulse per DLLP; pulses are mutually exclusive.

## Timing
- Reset values: all pulses 0; ack_seq_o, fc_*, pm_type_o and bad_dllp_count_o are 0; s_axis_tready = 0; FSM in IDLE.
- Result pulse latency: the pulse and its fields are registered and asserted exactly one cycle after the Beat B handshake.
- The CRC over bytes 0..3 is computed and registered on Beat A acceptance.
- Back-to-back DLLPs (Beat A on the cycle after Beat B) are sustained at full rate.
- Gaps (tvalid = 0) between Beat A and Beat B are allowed indefinitely.
- bad_dllp_o is asserted one cycle after the offending beat.
- bad_dllp_count_o updates on the same edge as bad_dllp_o and saturates at 0xFFFF.
- Reset asserted mid-DLLP: partial state is discarded, and the first beat after reset is treated as Beat A.
- link_up_i falling between Beat A and Beat B: the DLLP is dropped with no pulse.

## Test plan
- Ack with seq 0x005 and a correct CRC (bench reference model) → ack_valid_o = 1 for one cycle, one cycle after Beat B; ack_seq_o = 0x005.
- UpdateFC-P with HdrFC = 0x20 and DataFC = 0x180 → fc_valid_o pulse; fc_kind_o = 0, fc_type_o = 0, fc_hdr_o = 0x20, fc_data_o = 0x180.
- Nak with byte5 bit 0 flipped → no nak_valid_o; bad_dllp_o pulse; bad_dllp_count_o goes 0 → 1.
- Three-beat DLLP-flagged frame → bad_dllp_o once; remaining beats dropped; following valid InitFC1-NP is decoded correctly.
- Back-to-back stream of 8 Acks, seq 0..7 → 8 ack pulses on consecutive even cycles with matching seq; s_axis_tready held 1.
- Reset asserted after Beat A of an Ack, released, then a full InitFC2-Cpl sent → no Ack pulse; fc_kind_o = 2, fc_type_o = 2.
